calc_sequencer: RTL and testbench
=================================

# calc_sequencer

Control FSM for the simple calculator. Captures operands from the board switches on button pulses, sequences the selected arithmetic operation, and drives the registered `A`, `B`, `C` and `flag` values consumed by the VGA text renderer. Add, subtract and multiply complete in one cycle. Divide runs on an iterative sub-module. The block sits between the debounced button/switch front end and the display output stage.

## Interface
Parameters:
- `W`, 16: operand and result width; must match the display field width.

Ports:
- `clk` in, 1: system clock.
- `rst` in, 1: asynchronous, active-high reset.
- `sw` in, W: operand value from switches.
- `op` in, 2: opcode, sampled on `btn_exec`. 00 = ADD, 01 = SUB, 10 = MUL, 11 = DIV.
- `btn_load` in, 1: single-cycle pulse (debounced upstream) that captures `sw`.
- `btn_exec` in, 1: single-cycle pulse that starts the operation.
- `btn_clr` in, 1: single-cycle pulse that clears to the initial state.
- `A`, `B`, `C` out, W: registered operand A, operand B and result, all to the display.
- `flag` out, 1: registered error/overflow indication; the display shows a red background when set.
- `busy` out, 1: high in EXEC and DIV_RUN.

## Operation
- All arithmetic is unsigned.
- States:
  - ENTER_A
    - `btn_load`: A <= sw, go to ENTER_B.
    - `btn_exec`: ignored.
  - ENTER_B
    - `btn_load`: B <= sw, stay; B may be reloaded any number of times.
    - `btn_exec`: latch `op`, go to EXEC.
  - EXEC (one cycle)
    - ADD/SUB/MUL: write C and flag, go to DONE.
    - DIV with B != 0: start the divider, go to DIV_RUN.
    - DIV with B == 0: C <= 0, flag <= 1, go to DONE.
  - DIV_RUN
    - Wait for divider `done`, then C <= quotient, flag <= 0, go to DONE.
    - `btn_load` and `btn_exec` are ignored.
  - DONE
    - `btn_load`: A <= sw, B <= 0, C <= 0, flag <= 0, go to ENTER_B.
    - `btn_exec`: chain the result. A <= C, B <= 0, C <= 0, flag <= 0, go to ENTER_B.
- Arithmetic rules:
  - ADD: C = (A+B)[W-1:0]; flag = carry out.
  - SUB: C = (A-B) mod 2^W; flag = (A < B).
  - MUL: full 2W-bit product; C = low W bits; flag = (high W bits != 0).
  - DIV: C = A / B (quotient); remainder is discarded.
- `btn_clr` is legal in any state, including EXEC and DIV_RUN.
  - Effect: A = B = C = 0, flag = 0, go to ENTER_A.
  - In DIV_RUN it aborts the divider; a `done` from an aborted division must never write C.
- Priority when pulses coincide: `btn_clr` > `btn_load` > `btn_exec`.
- `flag` holds its value until the next load, chain or clear.

## Timing
- Reset values:
  - A = B = C = 0, flag = 0, busy = 0.
  - State = ENTER_A; divider idle.
- Pulses are sampled on the rising edge of `clk`. Let k be the edge at which `btn_exec` is sampled.
- ADD/SUB/MUL:
  - State = EXEC after edge k.
  - C/flag are updated and state = DONE at edge k+1.
  - busy is high for exactly one cycle.
- DIV:
  - Divider is started at edge k+1 and takes exactly W cycles.
  - C is updated and state = DONE at edge k+W+2 (k+18 for W = 16).
  - busy is high from k through k+W+2.
- Divide-by-zero completes with the ADD timing.
- `btn_clr` takes effect at the edge at which it is sampled.
- Outputs are registers only; there is no combinational path from inputs to outputs.

## Configuration
- Macro: `CALC_DIV_EN`.
- Defined:
  - DIV is implemented as described above.
  - `calc_divider` is instantiated.
- Undefined:
  - No divider is instantiated and DIV_RUN is unreachable.
  - DIV behaves like divide-by-zero: C = 0, flag = 1, one-cycle EXEC.

## Structure
- Package `calc_pkg`:
  - `W` default (16).
  - Opcode constants `OP_ADD`, `OP_SUB`, `OP_MUL`, `OP_DIV`.
  - FSM state enum.
  - `DIV_CYCLES` (= W).
- Sub-module `calc_divider`:
  - Restoring divider that processes one quotient bit per cycle.
  - Ports: `clk`, `rst`, `start`, `abort`, `dividend`, `divisor`, `quotient`, `done`.
  - `done` is a single-cycle pulse.
- ADD/SUB/MUL logic stays inline in the FSM.

## Test plan
- Reset:
  - Assert `rst` mid-DIV_RUN → A/B/C = 0, flag = 0, busy = 0, state ENTER_A; no late write after release.
- ADD:
  - A = 0x0003, B = 0x0004, exec → C = 0x0007, flag 0 at k+1.
  - A = 0xFFFF, B = 0x0001 → C = 0x0000, flag 1.
- SUB:
  - 0x0005 − 0x0007 → C = 0xFFFE, flag 1.
  - 0x0009 − 0x0002 → C = 0x0007, flag 0.
- MUL:
  - 0x0100 × 0x0100 → C = 0x0000, flag 1.
  - 0x00FF × 0x0002 → C = 0x01FE, flag 0.
- DIV (with `CALC_DIV_EN`):
  - 100 / 7 → C = 0x000E at k+18, busy high throughout.
  - B = 0 → C = 0, flag 1 at k+1.
  - Without the macro: 100 / 7 → C = 0, flag 1 at k+1.
- Boundaries:
  - `btn_clr` in DIV_RUN → cleared next edge, C stays 0.
  - `btn_load` + `btn_exec` together in ENTER_B → B loaded, no exec.
  - `btn_exec` in ENTER_A → ignored.
  - `btn_exec` in DONE with C = 0x0007 → A = 0x0007, B = 0, state ENTER_B.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared constants, opcodes and FSM state type for the calculator sequencer.
package calc_pkg;

  localparam int W          = 16;
  localparam int DIV_CYCLES = W;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [2:0] {
    ENTER_A = 3'd0,
    ENTER_B = 3'd1,
    EXEC    = 3'd2,
    DIV_RUN = 3'd3,
    DONE    = 3'd4
  } calc_state_t;

endpackage

// File: rtl/calc_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; only instantiated
// by calc_sequencer when CALC_DIV_EN is defined.
module calc_divider
  import calc_pkg::*;
#(
  parameter int W = calc_pkg::W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic         done
);

  localparam int CntW = $clog2(W + 1);

  logic [W-1:0]    r_rem;
  logic [W-1:0]    r_quo;
  logic [W-1:0]    r_dvs;
  logic [CntW-1:0] r_cnt;
  logic            r_done;
  logic [W:0]      w_shifted;
  logic [W:0]      w_trial;

  assign w_shifted = {r_rem, r_quo[W-1]};
  assign w_trial   = w_shifted - {1'b0, r_dvs};

  // Abort wins over start so a clear in the same cycle leaves the divider idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (abort) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (start) begin
      r_rem  <= '0;
      r_quo  <= dividend;
      r_dvs  <= divisor;
      r_cnt  <= CntW'(W);
      r_done <= 1'b0;
    end else if (r_cnt != '0) begin
      r_rem  <= w_trial[W] ? w_shifted[W-1:0] : w_trial[W-1:0];
      r_quo  <= {r_quo[W-2:0], ~w_trial[W]};
      r_cnt  <= r_cnt - 1'b1;
      r_done <= (r_cnt == CntW'(1));
    end else begin
      r_done <= 1'b0;
    end
  end

  assign quotient = r_quo;
  assign done     = r_done;

endmodule

// File: rtl/calc_sequencer.sv
// Calculator control FSM: operand capture, ADD/SUB/MUL inline, iterative DIV.
// Define CALC_DIV_EN to build the divider; otherwise DIV reports divide-by-zero.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int W = calc_pkg::W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] sw,
  input  logic [1:0]   op,
  input  logic         btn_load,
  input  logic         btn_exec,
  input  logic         btn_clr,
  output logic [W-1:0] A,
  output logic [W-1:0] B,
  output logic [W-1:0] C,
  output logic         flag,
  output logic         busy
);

  calc_state_t r_state, w_stateNext;
  logic [W-1:0] r_a, r_b, r_c, w_aNext, w_bNext, w_cNext;
  logic         r_flag, w_flagNext;
  logic [1:0]   r_op, w_opNext;
  logic [W:0]   w_sum;
  logic [W-1:0] w_diff;
  logic [2*W-1:0] w_prod;
  logic         w_divStart;
  logic         w_divAbort;

  assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff = r_a - r_b;
  assign w_prod = {{W{1'b0}}, r_a} * {{W{1'b0}}, r_b};

`ifdef CALC_DIV_EN
  logic [W-1:0] w_quot;
  logic         w_divDone;

  calc_divider #(.W(W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (w_divStart),
    .abort    (w_divAbort),
    .dividend (r_a),
    .divisor  (r_b),
    .quotient (w_quot),
    .done     (w_divDone)
  );
`endif

  always_comb begin
    w_stateNext = r_state;
    w_aNext     = r_a;
    w_bNext     = r_b;
    w_cNext     = r_c;
    w_flagNext  = r_flag;
    w_opNext    = r_op;
    w_divStart  = 1'b0;
    w_divAbort  = 1'b0;

    case (r_state)
      ENTER_A: begin
        if (btn_load) begin
          w_aNext     = sw;
          w_stateNext = ENTER_B;
        end
      end
      ENTER_B: begin
        if (btn_load) begin
          w_bNext = sw;
        end else if (btn_exec) begin
          w_opNext    = op;
          w_stateNext = EXEC;
        end
      end
      EXEC: begin
        w_stateNext = DONE;
        case (r_op)
          OP_ADD: begin
            w_cNext    = w_sum[W-1:0];
            w_flagNext = w_sum[W];
          end
          OP_SUB: begin
            w_cNext    = w_diff;
            w_flagNext = (r_a < r_b);
          end
          OP_MUL: begin
            w_cNext    = w_prod[W-1:0];
            w_flagNext = (w_prod[2*W-1:W] != '0);
          end
          default: begin
`ifdef CALC_DIV_EN
            if (r_b != '0) begin
              w_divStart  = 1'b1;
              w_stateNext = DIV_RUN;
            end else begin
              w_cNext    = '0;
              w_flagNext = 1'b1;
            end
`else
            w_cNext    = '0;
            w_flagNext = 1'b1;
`endif
          end
        endcase
      end
`ifdef CALC_DIV_EN
      DIV_RUN: begin
        if (w_divDone) begin
          w_cNext     = w_quot;
          w_flagNext  = 1'b0;
          w_stateNext = DONE;
        end
      end
`endif
      DONE: begin
        if (btn_load || btn_exec) begin
          w_aNext     = btn_load ? sw : r_c;
          w_bNext     = '0;
          w_cNext     = '0;
          w_flagNext  = 1'b0;
          w_stateNext = ENTER_B;
        end
      end
      default: w_stateNext = ENTER_A;
    endcase

    // Clear overrides everything and kills any in-flight division.
    if (btn_clr) begin
      w_aNext     = '0;
      w_bNext     = '0;
      w_cNext     = '0;
      w_flagNext  = 1'b0;
      w_divAbort  = 1'b1;
      w_stateNext = ENTER_A;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ENTER_A;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_flag  <= 1'b0;
      r_op    <= OP_ADD;
    end else begin
      r_state <= w_stateNext;
      r_a     <= w_aNext;
      r_b     <= w_bNext;
      r_c     <= w_cNext;
      r_flag  <= w_flagNext;
      r_op    <= w_opNext;
    end
  end

  assign A    = r_a;
  assign B    = r_b;
  assign C    = r_c;
  assign flag = r_flag;
  assign busy = (r_state == EXEC) || (r_state == DIV_RUN);

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer; expectations follow CALC_DIV_EN.
module tb_calc_sequencer;

  localparam int W = 16;

  typedef struct {
    string        tag;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic         flag;
    int           lat;
  } expT;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] sw = '0;
  logic [1:0]   op = 2'b00;
  logic         btnLoad = 1'b0;
  logic         btnExec = 1'b0;
  logic         btnClr = 1'b0;
  logic [W-1:0] A, B, C;
  logic         flag, busy;

  int  checkCount = 0;
  int  passCount  = 0;
  expT sbQ[$];

  calc_sequencer #(.W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .sw       (sw),
    .op       (op),
    .btn_load (btnLoad),
    .btn_exec (btnExec),
    .btn_clr  (btnClr),
    .A        (A),
    .B        (B),
    .C        (C),
    .flag     (flag),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  // Reference model of one operation; lat is the number of busy cycles.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [1:0] o, output logic [W-1:0] c,
                                output logic f, output int lat);
    logic [W:0]     s;
    logic [2*W-1:0] p;
    lat = 1;
    case (o)
      2'b00: begin s = {1'b0, a} + {1'b0, b}; c = s[W-1:0]; f = s[W]; end
      2'b01: begin c = a - b; f = (a < b); end
      2'b10: begin p = a * b; c = p[W-1:0]; f = (p[2*W-1:W] != 0); end
      default: begin
`ifdef CALC_DIV_EN
        if (b != 0) begin c = a / b; f = 1'b0; lat = W + 2; end
        else begin c = '0; f = 1'b1; end
`else
        c = '0; f = 1'b1;
`endif
      end
    endcase
  endfunction

  task automatic pulse(input logic l, input logic e, input logic c);
    @(negedge clk);
    btnLoad = l; btnExec = e; btnClr = c;
    @(negedge clk);
    btnLoad = 1'b0; btnExec = 1'b0; btnClr = 1'b0;
  endtask

  task automatic pushExpected(input string tag, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic [1:0] o);
    expT e;
    e.tag = tag; e.a = a; e.b = b;
    model(a, b, o, e.c, e.flag, e.lat);
    sbQ.push_back(e);
  endtask

  task automatic waitResult();
    expT e;
    int  lat = 0;
    while (busy && lat < 64) begin
      lat++;
      @(negedge clk);
    end
    if (sbQ.size() == 0) begin
      checkOutput("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sbQ.pop_front();
    checkOutput({e.tag, "_lat"}, lat, e.lat);
    checkOutput({e.tag, "_c"}, C, e.c);
    checkOutput({e.tag, "_flag"}, flag, e.flag);
    checkOutput({e.tag, "_a"}, A, e.a);
    checkOutput({e.tag, "_b"}, B, e.b);
  endtask

  task automatic applyStimulus(input string tag, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [1:0] o);
    pulse(1'b0, 1'b0, 1'b1);
    sw = a;
    pulse(1'b1, 1'b0, 1'b0);
    sw = b;
    pulse(1'b1, 1'b0, 1'b0);
    op = o;
    pushExpected(tag, a, b, o);
    pulse(1'b0, 1'b1, 1'b0);
    waitResult();
  endtask

  task automatic checkCleared(input string tag);
    checkOutput({tag, "_a"}, A, 32'd0);
    checkOutput({tag, "_b"}, B, 32'd0);
    checkOutput({tag, "_c"}, C, 32'd0);
    checkOutput({tag, "_flag"}, flag, 32'd0);
    checkOutput({tag, "_busy"}, busy, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkCleared("reset");
    rst = 1'b0;
    @(negedge clk);

    pulse(1'b0, 1'b1, 1'b0);
    checkOutput("execInEnterA_busy", busy, 32'd0);
    sw = 16'h0003;
    pulse(1'b1, 1'b0, 1'b0);
    checkOutput("loadA", A, 32'h0003);
    sw = 16'h0004;
    op = 2'b00;
    pulse(1'b1, 1'b1, 1'b0);
    checkOutput("loadExec_b", B, 32'h0004);
    checkOutput("loadExec_busy", busy, 32'd0);
    pushExpected("add3p4", 16'h0003, 16'h0004, 2'b00);
    pulse(1'b0, 1'b1, 1'b0);
    waitResult();

    pulse(1'b0, 1'b1, 1'b0);
    checkOutput("chain_a", A, 32'h0007);
    checkOutput("chain_b", B, 32'd0);
    checkOutput("chain_c", C, 32'd0);
    checkOutput("chain_busy", busy, 32'd0);
    sw = 16'h0002;
    pulse(1'b1, 1'b0, 1'b0);
    op = 2'b01;
    pushExpected("chainSub", 16'h0007, 16'h0002, 2'b01);
    pulse(1'b0, 1'b1, 1'b0);
    waitResult();

    applyStimulus("addCarry", 16'hFFFF, 16'h0001, 2'b00);
    applyStimulus("subBorrow", 16'h0005, 16'h0007, 2'b01);
    applyStimulus("sub", 16'h0009, 16'h0002, 2'b01);
    applyStimulus("mulOvf", 16'h0100, 16'h0100, 2'b10);
    applyStimulus("mul", 16'h00FF, 16'h0002, 2'b10);
    applyStimulus("div", 16'd100, 16'd7, 2'b11);
    applyStimulus("divZero", 16'd100, 16'd0, 2'b11);
    applyStimulus("divMax", 16'hFFFF, 16'h0001, 2'b11);
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] ra, rb;
      logic [1:0]   ro;
      ra = W'($urandom);
      rb = W'($urandom);
      ro = 2'($urandom_range(0, 3));
      applyStimulus($sformatf("rand%0d", i), ra, rb, ro);
    end

    pulse(1'b0, 1'b0, 1'b1);
    sw = 16'd100;
    pulse(1'b1, 1'b0, 1'b0);
    sw = 16'd7;
    pulse(1'b1, 1'b0, 1'b0);
    op = 2'b11;
    pulse(1'b0, 1'b1, 1'b0);
`ifdef CALC_DIV_EN
    repeat (4) @(negedge clk);
    checkOutput("divRun_busy", busy, 32'd1);
    pulse(1'b0, 1'b0, 1'b1);
`else
    btnClr = 1'b1;
    @(negedge clk);
    btnClr = 1'b0;
`endif
    checkCleared("clrBusy");
    repeat (25) @(negedge clk);
    checkCleared("clrBusyLate");

    sw = 16'd200;
    pulse(1'b1, 1'b0, 1'b0);
    sw = 16'd3;
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    checkCleared("rstMid");
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    checkCleared("rstMidLate");
    pulse(1'b0, 1'b1, 1'b0);
    checkOutput("rstMid_enterA_busy", busy, 32'd0);

    checkOutput("sb_drained", sbQ.size(), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
